// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 mux port. It drives a one-hot grant and the mux select,
// keeps at least one idle cycle between grants, and can revoke a grant after a hold limit.
module rr_mux4_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    if (MAX_HOLD < 0 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_param_check
        $error("rr_mux4_arbiter: MAX_HOLD must fit in CNT_W bits");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       next_owner;
    logic             hold_hit;
    logic             release_now;

    // The first requester found scanning ptr, ptr+1, ... wins, so the scan runs from the far end.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        next_owner  = pick(req, ptr);
        hold_hit    = (MAX_HOLD != 0) && (count == HOLD_LAST);
        release_now = done || !req[sel] || hold_hit;
    end

    assign busy = |grant;

    // NOTE: every register shares one reset and non-blocking assignments, so each branch reads the
    // values from before the edge. That matters for sel, ptr and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            sel     <= '0;
            ptr     <= '0;
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= 4'b0001 << next_owner;
                        sel   <= next_owner;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        grant   <= '0;
                        ptr     <= sel + 2'd1;
                        count   <= '0;
                        state   <= IDLE;
                        timeout <= hold_hit && !done && req[sel];
                    end else if (count != '1) begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter with MAX_HOLD=4. A table of per-cycle vectors is applied,
// followed by hand sequences that cover reset during a grant.
module tb_rr_mux4_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_vec  = 0;
    int n_miss = 0;

    rr_mux4_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       timeout;
    } vec_t;

    vec_t vecs[30];

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb, input logic et);
        n_vec++;
        if (grant !== eg || sel !== es || busy !== eb || timeout !== et || !$onehot0(grant)) begin
            n_miss++;
            $display("FAIL %s: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
                     name, grant, sel, busy, timeout, eg, es, eb, et);
        end
    endtask

    initial begin
        // Single requester 1, done after three granted cycles (ptr starts at 0)
        vecs[0]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[1]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
        // All four requesting with ptr=2, done in every granted cycle
        vecs[5]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[10] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[11] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[12] = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        // ptr=2 and only requester 0 is active, so the scan wraps. The owner then drops req together
        // with done, which should advance ptr once, to 1.
        vecs[13] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[15] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[16] = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[17] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        // Hold limit: exactly 4 granted cycles, then a revoke with a timeout pulse, then a re-grant.
        // Other requesters stay ignored while requester 3 owns the port.
        vecs[18] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[19] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[20] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[21] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[22] = '{4'b1000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1};
        vecs[23] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        // done coincides with the hold limit, so the release is normal and timeout stays 0
        vecs[24] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[25] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[26] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[27] = '{4'b1000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[28] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
        // After owner 3, ptr=0, so requester 2 wins here (this grant is reset below)
        vecs[29] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            req  = vecs[i].req;
            done = vecs[i].done;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].timeout);
        end

        // Asynchronous reset in the middle of the grant to requester 2
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check("held_in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        done  = 1'b0;
        @(posedge clk);
        #1 check("post_reset_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #1 check("post_reset_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        done = 1'b0;
        @(posedge clk);
        #1 check("post_reset_next_rr", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
